// File: rtl/matrix_pkg.sv
// Shared constants, matrix storage type and loader state encoding.
package matrix_pkg;

  localparam int MAT_N       = 4;
  localparam int MAT_ELEMS   = MAT_N * MAT_N;
  localparam int ELEM_W      = 8;
  localparam int FRAME_BEATS = 2 * MAT_ELEMS;
  localparam int IDX_W       = $clog2(FRAME_BEATS);
  localparam int MAT_W       = MAT_ELEMS * ELEM_W;

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_START    = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_e;

  // Element n sits at bits [8n+7:8n], row-major.
  typedef logic [MAT_ELEMS-1:0][ELEM_W-1:0] mat_t;

  // True when idx addresses the last beat of a frame (last element of B).
  function automatic logic is_final_beat(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(FRAME_BEATS - 1);
  endfunction

endpackage

// File: rtl/mm_watchdog.sv
// Counts cycles while enabled; flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module mm_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear dominates, otherwise count enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the number of enabled cycles already elapsed, so the
  // TIMEOUT_CYCLES-th enabled cycle sees TIMEOUT_CYCLES-1.
  assign expired = enable && !clear && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/matrix_loader.sv
// Loads a 32-byte frame into matrices A and B, then handshakes with the
// multiplier (mm_start / mm_done) under a watchdog timeout.
// Optional: MATRIX_LOADER_FRAME_CHECK_EN enables s_last framing checks.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [ELEM_W-1:0] s_data,
  input  logic             s_last,
  output logic [MAT_W-1:0] mat_a,
  output logic [MAT_W-1:0] mat_b,
  output logic             mm_start,
  input  logic             mm_done,
  output logic             busy,
  input  logic             err_clr,
  output logic             err_timeout,
  output logic             frame_err
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  mat_t              mat_a_q, mat_a_d;
  mat_t              mat_b_q, mat_b_d;
  logic              s_ready_q, s_ready_d;
  logic              err_q, err_d;
  logic              err_set;
  logic              beat_acc;
  logic              last_beat;
  logic              wd_expired;

  assign beat_acc = s_valid && s_ready_q;

  mm_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (state_q == ST_START),
    .clear   (state_q != ST_START),
    .expired (wd_expired)
  );

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
  logic frame_err_q, frame_err_d;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
`endif

  // Next-state, matrix capture and index update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mat_a_d   = mat_a_q;
    mat_b_d   = mat_b_q;
    err_set   = 1'b0;
    last_beat = is_final_beat(idx_q);
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
    frame_err_d = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (beat_acc) begin
          // idx[4] picks the matrix, idx[3:0] the element.
          if (!idx_q[IDX_W-1]) mat_a_d[idx_q[IDX_W-2:0]] = s_data;
          else                 mat_b_d[idx_q[IDX_W-2:0]] = s_data;
          idx_d = idx_q + IDX_W'(1);
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
          if (s_last != last_beat) begin
            // Misframed stream: drop the frame, resync at element 0 of A.
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else if (last_beat) begin
            idx_d   = '0;
            state_d = ST_START;
          end
`else
          if (last_beat) begin
            idx_d   = '0;
            state_d = ST_START;
          end
`endif
        end
      end
      ST_START: begin
        // A real completion wins over a same-cycle timeout.
        if (mm_done) begin
          state_d = ST_WAIT_CLR;
        end else if (wd_expired) begin
          state_d = ST_WAIT_CLR;
          err_set = 1'b1;
        end
      end
      ST_WAIT_CLR: begin
        if (!mm_done) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Sticky timeout flag: a new timeout beats a coincident clear.
  always_comb begin
    err_d = err_q;
    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  // s_ready is registered so it stays low during reset and rises on the
  // first edge after release.
  always_comb begin
    s_ready_d = (state_d == ST_LOAD);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      idx_q     <= '0;
      mat_a_q   <= '0;
      mat_b_q   <= '0;
      s_ready_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mat_a_q   <= mat_a_d;
      mat_b_q   <= mat_b_d;
      s_ready_q <= s_ready_d;
      err_q     <= err_d;
    end
  end

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
  // One-cycle frame error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign s_ready     = s_ready_q;
  assign mat_a       = mat_a_q;
  assign mat_b       = mat_b_q;
  assign mm_start    = (state_q == ST_START);
  assign busy        = (state_q != ST_LOAD);
  assign err_timeout = err_q;

endmodule
